// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed multiply / divide engine.
// Multiply is shift-add on magnitudes (LSB first); divide is restoring (MSB first).
// Signs are latched at start and applied once in FIX, so the outputs only update there.
// Optional build macro MULDIV_EARLY_EXIT_EN: the multiply ends once the remaining
// multiplier bits are all zero (at least one iteration). Divide is unaffected.
module muldiv_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mul_start,
  input  logic               div_start,
  input  logic [WIDTH-1:0]   mul_input_a,
  input  logic [WIDTH-1:0]   mul_input_b,
  input  logic [WIDTH-1:0]   div_dividend,
  input  logic [WIDTH-1:0]   div_divisor,
  output logic               busy,
  output logic               mul_done,
  output logic [2*WIDTH-1:0] mul_product,
  output logic               div_done,
  output logic [WIDTH-1:0]   div_quotient,
  output logic [WIDTH-1:0]   div_remainder,
  output logic               div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_mul_q, is_mul_d;
  logic                 sign_q, sign_d;      // product / quotient sign
  logic                 rsign_q, rsign_d;    // remainder sign (dividend sign)
  logic                 dz_q, dz_d;          // divisor was zero
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;        // dividend shifts out, quotient shifts in
  logic [WIDTH:0]       dsor_q, dsor_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     remo_q, remo_d;
  logic                 mul_done_q, mul_done_d;
  logic                 div_done_q, div_done_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH-1:0]     mplier_shift;

  // Unsigned magnitude; W bits hold 2^(W-1) exactly, so -2^(W-1) loses nothing.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign div_trial    = {rem_q, quo_q[WIDTH-1]};
  assign mplier_shift = mplier_q >> 1;

  // Next-state: operand capture, one iteration per clock, sign fix-up in FIX.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_mul_d   = is_mul_q;
    sign_d     = sign_q;
    rsign_d    = rsign_q;
    dz_d       = dz_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dsor_d     = dsor_q;
    prod_d     = prod_q;
    quot_d     = quot_q;
    remo_d     = remo_q;
    mul_done_d = 1'b0;
    div_done_d = 1'b0;
    dbz_d      = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (mul_start) begin
          sign_d   = mul_input_a[WIDTH-1] ^ mul_input_b[WIDTH-1];
          mcand_d  = {{WIDTH{1'b0}}, mag(mul_input_a)};
          mplier_d = mag(mul_input_b);
          acc_d    = '0;
          cnt_d    = '0;
          is_mul_d = 1'b1;
          dbz_d    = 1'b0;
          state_d  = StMul;
        end else if (div_start) begin
          sign_d   = div_dividend[WIDTH-1] ^ div_divisor[WIDTH-1];
          rsign_d  = div_dividend[WIDTH-1];
          quo_d    = mag(div_dividend);
          rem_d    = '0;
          dsor_d   = {1'b0, mag(div_divisor)};
          dz_d     = (div_divisor == '0);
          cnt_d    = '0;
          is_mul_d = 1'b0;
          dbz_d    = 1'b0;
          state_d  = StDiv;
        end
      end
      StMul: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
`ifdef MULDIV_EARLY_EXIT_EN
        else if (mplier_shift == '0) begin
          state_d = StFix;
        end
`endif
      end
      StDiv: begin
        // Divisor 0 always "fits": quotient bits go to all ones, remainder to the dividend.
        if (div_trial >= dsor_q) begin
          rem_d = WIDTH'(div_trial - dsor_q);
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) state_d = StFix;
      end
      StFix: begin
        if (is_mul_q) begin
          prod_d     = sign_q ? (~acc_q + 1'b1) : acc_q;
          mul_done_d = 1'b1;
        end else begin
          quot_d     = dz_q ? '1 : (sign_q ? (~quo_q + 1'b1) : quo_q);
          remo_d     = rsign_q ? (~rem_q + 1'b1) : rem_q;
          div_done_d = 1'b1;
          dbz_d      = dz_q;
        end
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_mul_q   <= 1'b0;
      sign_q     <= 1'b0;
      rsign_q    <= 1'b0;
      dz_q       <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsor_q     <= '0;
      prod_q     <= '0;
      quot_q     <= '0;
      remo_q     <= '0;
      mul_done_q <= 1'b0;
      div_done_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_mul_q   <= is_mul_d;
      sign_q     <= sign_d;
      rsign_q    <= rsign_d;
      dz_q       <= dz_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dsor_q     <= dsor_d;
      prod_q     <= prod_d;
      quot_q     <= quot_d;
      remo_q     <= remo_d;
      mul_done_q <= mul_done_d;
      div_done_q <= div_done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign mul_done      = mul_done_q;
  assign mul_product   = prod_q;
  assign div_done      = div_done_q;
  assign div_quotient  = quot_q;
  assign div_remainder = remo_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a negedge
// monitor pops and compares whenever a done pulse appears.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mul_start, div_start;
  logic [15:0] mul_input_a, mul_input_b, div_dividend, div_divisor;
  logic        busy, mul_done, div_done, div_by_zero;
  logic [31:0] mul_product;
  logic [15:0] div_quotient, div_remainder;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mul_start    (mul_start),
    .div_start    (div_start),
    .mul_input_a  (mul_input_a),
    .mul_input_b  (mul_input_b),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .busy         (busy),
    .mul_done     (mul_done),
    .mul_product  (mul_product),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mul;
    logic [31:0] prod;
    logic [15:0] q;
    logic [15:0] r;
    bit          dbz;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (op %0d): got %h, expected %h", nm, id, act, exp);
    end
  endtask

  function automatic int mul_lat(input logic [15:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
    logic [15:0] m;
    int n;
    m = b[15] ? (~b + 16'd1) : b;
    n = 1;
    for (int i = 0; i < 16; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return 17;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (mul_done || div_done)) begin
      if (sb.size() == 0) begin
        chk("spurious_done", -1, 32'({mul_done, div_done}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", mon_e.id, cyc, mon_e.cyc);
        chk("mul_done", mon_e.id, 32'(mul_done), 32'(mon_e.is_mul));
        chk("div_done", mon_e.id, 32'(div_done), 32'(!mon_e.is_mul));
        if (mon_e.is_mul) begin
          chk("product", mon_e.id, mul_product, mon_e.prod);
        end else begin
          chk("quotient", mon_e.id, 32'(div_quotient), 32'(mon_e.q));
          chk("remainder", mon_e.id, 32'(div_remainder), 32'(mon_e.r));
          chk("div_by_zero", mon_e.id, 32'(div_by_zero), 32'(mon_e.dbz));
        end
      end
    end
  end

  // Waits (bounded) for a done pulse, counting busy cycles on the way.
  task automatic wait_done(input int exp_busy);
    int bc;
    bit hit;
    bc  = 0;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mul_done || div_done) begin
        hit = 1'b1;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
    chk("done_seen", next_id - 1, 32'(hit), 32'd1);
    if (hit) begin
      chk("busy_in_done", next_id - 1, 32'(busy), 32'd0);
      chk("busy_cycles", next_id - 1, bc, exp_busy);
    end
  endtask

  task automatic push_mul(input logic [31:0] p, input int lat);
    exp_t e;
    e.is_mul = 1'b1; e.prod = p; e.q = '0; e.r = '0; e.dbz = 1'b0;
    e.cyc = cyc + 1 + lat; e.id = next_id++;
    sb.push_back(e);
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
    int lat;
    lat = mul_lat(b);
    push_mul(p, lat);
    mul_input_a = a; mul_input_b = b; mul_start = 1'b1;
    @(negedge clk);
    mul_start = 1'b0; mul_input_a = '0; mul_input_b = '0;
    wait_done(lat);
  endtask

  task automatic run_div(input logic [15:0] n, input logic [15:0] d, input logic [15:0] q,
                         input logic [15:0] r, input bit dbz);
    exp_t e;
    e.is_mul = 1'b0; e.prod = '0; e.q = q; e.r = r; e.dbz = dbz;
    e.cyc = cyc + 18; e.id = next_id++;
    sb.push_back(e);
    div_dividend = n; div_divisor = d; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0; div_dividend = '0; div_divisor = '0;
    wait_done(17);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    mul_start = 1'b0; div_start = 1'b0;
    mul_input_a = '0; mul_input_b = '0; div_dividend = '0; div_divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", -1, 32'(busy), 32'd0);
    chk("rst_done", -1, 32'({mul_done, div_done, div_by_zero}), 32'd0);
    chk("rst_product", -1, mul_product, 32'd0);
    chk("rst_qr", -1, {div_quotient, div_remainder}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiplies, then divides issued back to back (start lands in the done cycle).
    run_mul(16'd7, 16'hFFFD, 32'hFFFF_FFEB);
    run_mul(16'h8000, 16'h8000, 32'h4000_0000);
    run_mul(16'd0, 16'd1234, 32'h0000_0000);
    run_div(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0);
    run_div(16'd7, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0);
    run_div(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    run_div(16'd100, 16'd0, 16'hFFFF, 16'h0064, 1'b1);
    run_div(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

    // Both starts together: multiply wins; a div_start while busy is dropped.
    lat = mul_lat(16'h4000);
    push_mul(32'h0000_C000, lat);
    mul_input_a = 16'd3; mul_input_b = 16'h4000; mul_start = 1'b1;
    div_dividend = 16'd50; div_divisor = 16'd5; div_start = 1'b1;
    @(negedge clk);
    mul_start = 1'b0; div_start = 1'b0;
    repeat (4) @(negedge clk);
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    wait_done(lat - 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_product", i, mul_product, 32'h0000_C000);
      chk("hold_quotient", i, 32'(div_quotient), 32'd3);
    end

    // Asynchronous reset in the middle of a multiply.
    mul_input_a = 16'd1000; mul_input_b = 16'hF830; mul_start = 1'b1;
    @(negedge clk);
    mul_start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", -1, 32'(busy), 32'd0);
    chk("midrst_done", -1, 32'({mul_done, div_done, div_by_zero}), 32'd0);
    chk("midrst_product", -1, mul_product, 32'd0);
    chk("midrst_qr", -1, {div_quotient, div_remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", -1, 32'({mul_done, div_done}), 32'd0);
    run_mul(16'd3, 16'd5, 32'd15);

    repeat (3) @(negedge clk);
    chk("sb_drained", -1, sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
